// File: rtl/m10_seq.sv
// Sequencer that streams one packed binary row from memory into the first-moment
// datapath, then waits for the datapath's result and captures it.
module m10_seq #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [8:0]  n_words,
  input  logic [10:0] x_origin,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  idata,
  output logic [10:0] hcount,
  output logic        cnt_en,
  output logic        rd_done,
  input  logic        m10_done,
  input  logic [31:0] m10_data,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_TAIL,
    S_FIN,
    S_WAIT
  } state_t;

  state_t      state_q;
  logic [15:0] base_q;
  logic [8:0]  n_q;
  logic [10:0] x_q;
  logic [8:0]  idx_q;
  logic [TW-1:0] tcnt_q;
  logic        mem_rd_q;
  logic [15:0] mem_addr_q;
  logic [10:0] hcount_q;
  logic        cnt_en_q;
  logic        rd_done_q;
  logic        busy_q;
  logic [31:0] result_q;
  logic        result_valid_q;
  logic        err_q;
  logic        rd_dly_q;

  // All outputs are registered and computed on the transition into the state
  // that presents them, so each state's outputs appear in its first cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      n_q            <= '0;
      x_q            <= '0;
      idx_q          <= '0;
      tcnt_q         <= '0;
      mem_rd_q       <= 1'b0;
      mem_addr_q     <= '0;
      hcount_q       <= '0;
      cnt_en_q       <= 1'b0;
      rd_done_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      rd_dly_q       <= 1'b0;
    end else begin
      err_q          <= 1'b0;
      result_valid_q <= 1'b0;
      rd_dly_q       <= mem_rd_q;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (n_words == '0) begin
              err_q <= 1'b1;
            end else begin
              base_q   <= base_addr;
              n_q      <= n_words;
              x_q      <= x_origin;
              cnt_en_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= S_CLR;
            end
          end
        end
        S_CLR: begin
          cnt_en_q   <= 1'b0;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= base_q;
          hcount_q   <= x_q;
          idx_q      <= '0;
          state_q    <= S_RD;
        end
        S_RD: begin
          if (idx_q == n_q - 9'd1) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            hcount_q   <= '0;
            state_q    <= S_TAIL;
          end else begin
            idx_q      <= idx_q + 9'd1;
            mem_addr_q <= mem_addr_q + 16'd1;
            hcount_q   <= hcount_q + 11'd8;
          end
        end
        S_TAIL: begin
          rd_done_q <= 1'b1;
          state_q   <= S_FIN;
        end
        S_FIN: begin
          rd_done_q <= 1'b0;
          tcnt_q    <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (m10_done) begin
            result_q       <= m10_data;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign hcount       = hcount_q;
  assign cnt_en       = cnt_en_q;
  assign rd_done      = rd_done_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  // Read data arrives one cycle after the strobe; pass it straight through then.
  assign idata        = rd_dly_q ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_m10_seq.sv
// Directed bench for m10_seq with a memory model and a behavioural first-moment
// datapath (4-stage pipelined accumulator, rd_done delayed 9 cycles).
module tb_m10_seq;

  localparam int unsigned TO = 32;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] base_addr;
  logic [8:0]  n_words;
  logic [10:0] x_origin;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  idata;
  logic [10:0] hcount;
  logic        cnt_en;
  logic        rd_done;
  logic        m10_done = 1'b0;
  logic [31:0] m10_data = '0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        err;

  m10_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
    .n_words(n_words), .x_origin(x_origin), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .idata(idata),
    .hcount(hcount), .cnt_en(cnt_en), .rd_done(rd_done),
    .m10_done(m10_done), .m10_data(m10_data), .busy(busy),
    .result(result), .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr[7:0]] : 8'h5A;

  // Datapath model: hcount leads idata by one cycle
  bit          hold_done = 1'b0;
  logic [10:0] hc_d = '0;
  logic [31:0] pipe [4] = '{default: '0};
  logic [31:0] acc = '0;
  logic [8:0]  rsh = '0;

  function automatic logic [31:0] contrib(input logic [7:0] d, input logic [10:0] hc);
    logic [31:0] s = 0;
    for (int b = 0; b < 8; b++)
      if (d[7-b]) s += 32'(11'(hc + 11'(b)));
    return s;
  endfunction

  always @(posedge clk) begin
    hc_d    <= hcount;
    pipe[0] <= contrib(idata, hc_d);
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    acc      <= cnt_en ? 32'd0 : acc + pipe[3];
    rsh      <= {rsh[7:0], rd_done};
    m10_done <= rsh[8] & ~hold_done;
    m10_data <= acc;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int t_rd, t_rv, t_err, n_rv, n_err, n_rd, n_cnt;

  // Cycle 0 is the cycle with start high; k counts cycles after it.
  task automatic run_row(input logic [8:0] n, input logic [15:0] base,
                         input logic [10:0] x, input bit hold, input bit mid);
    bit seen = 1'b0;
    hold_done = hold;
    t_rd = -1; t_rv = -1; t_err = -1; n_rv = 0; n_err = 0; n_rd = 0; n_cnt = 0;
    @(negedge clk);
    base_addr = base; n_words = n; x_origin = x; start = 1'b1;
    for (int k = 1; k <= 150 && !seen; k++) begin
      @(negedge clk);
      start = mid && (k == 3);
      if (mem_rd) n_rd++;
      if (cnt_en) n_cnt++;
      if (rd_done && t_rd < 0) t_rd = k;
      if (result_valid) begin n_rv++; t_rv = k; seen = 1'b1; end
      if (err) begin n_err++; t_err = k; seen = 1'b1; end
      if (seen) chk("busy_fall", busy, 0);
      if (k == 1) chk("cnt_en_clr", cnt_en, 1);
      if (k >= 2 && k <= 32'(n) + 1) begin
        chk("rd_strobe", mem_rd, 1);
        chk("rd_addr", mem_addr, base + 16'(k - 2));
        chk("rd_hcount", hcount, 11'(x + 11'(8 * (k - 2))));
      end
      if (k >= 3 && k <= 32'(n) + 2) chk("idata", idata, mem[8'(base + 16'(k - 3))]);
      if (k == 1 || k == 32'(n) + 3) chk("idata_zero", idata, 0);
    end
    if (!seen) chk("run_bound", 0, 1);
    start = 1'b0;
    hold_done = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; base_addr = '0; n_words = '0; x_origin = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_flags", {mem_rd, cnt_en, rd_done, busy, result_valid, err}, 0);
    chk("rst_result", result, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // N=2, x=16, 0xFF 0x00 -> 16..23
    mem[8'h00] = 8'hFF; mem[8'h01] = 8'h00;
    run_row(9'd2, 16'h0100, 11'd16, 1'b0, 1'b0);
    chk("t1_result", result, 156);
    chk("t1_rv_cnt", n_rv, 1);
    chk("t1_rd_cnt", n_rd, 2);
    chk("t1_cnt_en", n_cnt, 1);
    chk("t1_rd_done_lat", t_rd, 5);
    chk("t1_rv_lat", t_rv, 16);

    // N=1, x=0, 0x01 -> position 7
    mem[8'h10] = 8'h01;
    run_row(9'd1, 16'h0010, 11'd0, 1'b0, 1'b0);
    chk("t2_result", result, 7);
    chk("t2_rd_done_lat", t_rd, 4);
    chk("t2_rv_after_rd_done", t_rv - t_rd, 11);

    // n_words=0 is rejected
    @(negedge clk);
    n_words = 9'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_no_rd", mem_rd, 0);
    @(negedge clk);
    chk("t3_err_pulse", err, 0);
    chk("t3_idle", {busy, mem_rd, cnt_en}, 0);

    // start during RD ignored; 0x80..0x01 at x=100 -> 100 + 131
    mem[8'h20] = 8'h80; mem[8'h21] = 8'h00; mem[8'h22] = 8'h00; mem[8'h23] = 8'h01;
    run_row(9'd4, 16'h0020, 11'd100, 1'b0, 1'b1);
    chk("t4_result", result, 231);
    chk("t4_rv_cnt", n_rv, 1);
    chk("t4_no_err", n_err, 0);
    chk("t4_rd_cnt", n_rd, 4);
    @(negedge clk);
    chk("t4_idle_after", {busy, mem_rd, cnt_en}, 0);

    // datapath withholds m10_done -> timeout err TO cycles after WAIT entry
    mem[8'h30] = 8'hAA;
    run_row(9'd1, 16'h0030, 11'd0, 1'b1, 1'b0);
    chk("t5_err_cnt", n_err, 1);
    chk("t5_err_time", t_err, 1 + 4 + TO);
    chk("t5_no_rv", n_rv, 0);
    chk("t5_result_kept", result, 231);

    // reset in RD cycle 3 of an 8-word run
    @(negedge clk);
    base_addr = 16'h0040; n_words = 9'd8; x_origin = 11'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_in_rd", {mem_rd, mem_addr}, {1'b1, 16'h0043});
    nrst = 1'b0;
    #1;
    chk("t6_rst_addr_data", {mem_addr, idata}, 0);
    chk("t6_rst_flags", {hcount, mem_rd, cnt_en, rd_done, busy, result_valid, err}, 0);
    chk("t6_rst_result", result, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    n_rd = 0; n_cnt = 0; t_rd = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_rd) n_rd++;
      if (cnt_en) n_cnt++;
      if (rd_done) t_rd++;
    end
    chk("t6_quiet", {n_rd[7:0], n_cnt[7:0], t_rd[7:0]}, 0);
    mem[8'h50] = 8'h80;
    run_row(9'd1, 16'h0050, 11'd5, 1'b0, 1'b0);
    chk("t6_result", result, 5);

    // x_origin=2044, 0xFF -> 2044..2047,0..3
    mem[8'h60] = 8'hFF;
    run_row(9'd1, 16'h0060, 11'd2044, 1'b0, 1'b0);
    chk("t7_result", result, 8188);
    chk("t7_rv_cnt", n_rv, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m10_seq.md
M10_SEQ -- requirements
Module: m10_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32, the maximum cycles WAIT may last for m10_done.
REQ-002 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port nrst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  in  1  single-cycle request to process one packed binary row.
REQ-005 SHALL have port base_addr  in  16  byte address of the first packed word.
REQ-006 SHALL have port n_words  in  9  number of 8-pixel words in the row, valid range 1..256.
REQ-007 SHALL have port x_origin  in  11  column index of the MSB pixel of the first word.
REQ-008 SHALL have port mem_rd  out  1  memory read strobe.
REQ-009 SHALL have port mem_addr  out  16  memory read address.
REQ-010 SHALL have port mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have port idata  out  8  packed pixels to the datapath, bit 7 = leftmost pixel.
REQ-012 SHALL have port hcount  out  11  column of idata[7], driven 1 cycle ahead of the matching idata.
REQ-013 SHALL have port cnt_en  out  1  datapath accumulator clear.
REQ-014 SHALL have port rd_done  out  1  end-of-row pulse to the datapath.
REQ-015 SHALL have port m10_done  in  1  datapath result-valid pulse.
REQ-016 SHALL have port m10_data  in  32  datapath first-moment result.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port result  out  32  captured moment, held until the next capture.
REQ-019 SHALL have port result_valid  out  1  1-cycle pulse when result is updated.
REQ-020 SHALL have port err  out  1  1-cycle pulse on a rejected start or a timeout.

Function
REQ-021 SHALL implement states IDLE, CLR, RD, TAIL, FIN and WAIT, with one-hot or binary encoding.
REQ-022 IDLE + start + n_words!=0 SHALL latch base_addr, n_words and x_origin, then go to CLR; the latched values SHALL stay stable for the whole run.
REQ-023 IDLE + start + n_words==0 SHALL pulse err, stay in IDLE, and issue no read.
REQ-024 start outside IDLE SHALL be ignored, with no err.
REQ-025 CLR SHALL last 1 cycle with cnt_en=1, then go to RD; cnt_en SHALL be 0 in all other states.
REQ-026 RD SHALL last exactly N cycles; in cycle i (0..N-1): mem_rd=1, mem_addr=base+i (16-bit wrap), hcount=x_origin+8*i (11-bit modulo wrap).
REQ-027 idata SHALL equal mem_rdata in the cycle after each mem_rd, and SHALL be 8'h00 in all other cycles.
REQ-028 hcount SHALL be 0 outside RD; mem_addr SHALL be 0 when mem_rd=0.
REQ-029 TAIL SHALL last 1 cycle and present the last idata word.
REQ-030 FIN SHALL last 1 cycle with rd_done=1, then go to WAIT; rd_done SHALL be 0 elsewhere.
REQ-031 WAIT SHALL capture m10_data into result on m10_done, pulse result_valid the next cycle, and return to IDLE.
REQ-032 WAIT SHALL pulse err and return to IDLE, leaving result unchanged, if TIMEOUT cycles pass without m10_done.
REQ-033 m10_done outside WAIT SHALL be ignored.
REQ-034 busy SHALL fall in the same cycle result_valid or the timeout err is asserted.
REQ-035 Latency from start to rd_done SHALL be N+3 cycles; with the datapath's 9-deep rd_done delay, result_valid SHALL follow rd_done by 11 cycles.

Reset
REQ-036 nrst low SHALL force IDLE, with all outputs 0 (result=0), regardless of state, including mid-RD.
REQ-037 After reset release, no spurious mem_rd, cnt_en or rd_done SHALL occur until a new start.

Verification
REQ-038 Bench SHALL use a behavioural datapath model that sums the hcount position of every set pixel, pipelined 4 stages, with rd_done delayed 9 cycles.
REQ-039 SHALL cover: N=2, x_origin=16, words 0xFF,0x00 -> result=156, result_valid once, mem_addr base, base+1.
REQ-040 SHALL cover: N=1, x_origin=0, word 0x01 -> result=7; rd_done 4 cycles after start, result_valid 11 cycles after rd_done.
REQ-041 SHALL cover: n_words=0 -> err pulse, busy stays 0, no mem_rd; start during RD -> ignored, result unchanged.
REQ-042 SHALL cover: model withholds m10_done -> err exactly TIMEOUT cycles after WAIT entry, result keeps its prior value.
REQ-043 SHALL cover: nrst asserted in RD cycle 3 of N=8 -> all outputs 0 immediately; a following N=1 run with word 0x80 at x_origin=5 -> result=5.
REQ-044 SHALL cover: x_origin=2044, N=1, word 0xFF -> hcount wraps modulo 2048, and result matches the model's 11-bit wrapped positions.
